// File: rtl/counter_step_controller.sv
// Tick-paced step counter: one step per button press, auto-repeat while held,
// with synchronous preset load, up/down direction and wrap/saturate overflow.
module counter_step_controller #(
  parameter int SIZE         = 4,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int TICK_BITS    = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tick,
  input  logic            stepLevel,
  input  logic            down,
  input  logic            load,
  input  logic [SIZE-1:0] loadValue,
  input  logic            wrapEnable,
  output logic [SIZE-1:0] value,
  output logic            stepPulse,
  output logic            carry,
  output logic            holding
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam logic [TICK_BITS-1:0] HOLD_LAST   = TICK_BITS'(HOLD_TICKS - 1);
  localparam logic [TICK_BITS-1:0] REPEAT_LAST = TICK_BITS'(REPEAT_TICKS - 1);

  state_t                state;
  logic [TICK_BITS-1:0]  tickCount;
  logic                  prevStep;
  logic                  pressEdge;
  logic                  stepReq;
  logic [SIZE+1:0]       stepRes;

  // Returns {applied, wrapped, nextValue}; a saturating overflow is not applied.
  function automatic logic [SIZE+1:0] stepCalc(input logic [SIZE-1:0] cur,
                                               input logic dn,
                                               input logic wrap);
    logic [SIZE-1:0] maxV;
    logic [SIZE-1:0] nxt;
    maxV = '1;
    nxt  = dn ? (cur - 1'b1) : (cur + 1'b1);
    if ((!dn && cur == maxV) || (dn && cur == '0))
      return wrap ? {1'b1, 1'b1, nxt} : {2'b00, cur};
    return {1'b1, 1'b0, nxt};
  endfunction

  assign pressEdge = stepLevel & ~prevStep;
  assign stepRes   = stepCalc(value, down, wrapEnable);

  always_comb begin
    stepReq = 1'b0;
    case (state)
      IDLE:    stepReq = pressEdge;
      HOLD:    stepReq = stepLevel & tick & (tickCount == HOLD_LAST);
      REPEAT:  stepReq = stepLevel & tick & (tickCount == REPEAT_LAST);
      default: stepReq = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value     <= '0;
      stepPulse <= 1'b0;
      carry     <= 1'b0;
      holding   <= 1'b0;
      state     <= IDLE;
      tickCount <= '0;
      prevStep  <= 1'b1;
    end else begin
      prevStep  <= stepLevel;
      stepPulse <= 1'b0;
      carry     <= 1'b0;

      // A load discards any step in the same clock; the FSM below is unaffected.
      if (load) begin
        value <= loadValue;
      end else if (stepReq && stepRes[SIZE+1]) begin
        value     <= stepRes[SIZE-1:0];
        stepPulse <= 1'b1;
        carry     <= stepRes[SIZE];
      end

      case (state)
        IDLE: begin
          if (pressEdge) begin
            state     <= HOLD;
            tickCount <= '0;
            holding   <= 1'b1;
          end
        end
        HOLD: begin
          if (!stepLevel) begin
            state     <= IDLE;
            tickCount <= '0;
            holding   <= 1'b0;
          end else if (tick) begin
            if (tickCount == HOLD_LAST) begin
              state     <= REPEAT;
              tickCount <= '0;
            end else begin
              tickCount <= tickCount + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (!stepLevel) begin
            state     <= IDLE;
            tickCount <= '0;
            holding   <= 1'b0;
          end else if (tick) begin
            if (tickCount == REPEAT_LAST) tickCount <= '0;
            else                          tickCount <= tickCount + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          tickCount <= '0;
          holding   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_step_controller.sv
// Bench for counter_step_controller: default-timing and short-timing instances
// share stimulus and are compared every clock against a press/tick-count model.
module tb_counter_step_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, stepLevel = 1'b0, down = 1'b0, load = 1'b0, wrapEnable = 1'b1;
  logic [3:0] loadValue = 4'h0;
  logic [3:0] vA, vB;
  logic       spA, cA, hA, spB, cB, hB;

  int total = 0;
  int bad   = 0;

  counter_step_controller dutA (
    .clock(clock), .reset(reset), .tick(tick), .stepLevel(stepLevel), .down(down),
    .load(load), .loadValue(loadValue), .wrapEnable(wrapEnable),
    .value(vA), .stepPulse(spA), .carry(cA), .holding(hA));

  counter_step_controller #(.SIZE(4), .HOLD_TICKS(5), .REPEAT_TICKS(2), .TICK_BITS(4)) dutB (
    .clock(clock), .reset(reset), .tick(tick), .stepLevel(stepLevel), .down(down),
    .load(load), .loadValue(loadValue), .wrapEnable(wrapEnable),
    .value(vB), .stepPulse(spB), .carry(cB), .holding(hB));

  always #5 clock = ~clock;

  // Reference: a press steps at once; afterwards the n-th tick while held steps
  // when n >= H and (n - H) is a multiple of R.
  int H [2] = '{500, 5};
  int R [2] = '{100, 2};
  int mVal [2], mN [2];
  bit mPrev [2], mAct [2], mPulse [2], mCarry [2];

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mVal[i] = 0; mN[i] = 0; mPrev[i] = 1; mAct[i] = 0; mPulse[i] = 0; mCarry[i] = 0;
    end
  endtask

  task automatic modelStep(input int i);
    bit stepNow;
    int t;
    stepNow = 0;
    if (mAct[i]) begin
      if (!stepLevel) mAct[i] = 0;
      else if (tick) begin
        mN[i]++;
        if (mN[i] >= H[i] && (mN[i] - H[i]) % R[i] == 0) stepNow = 1;
      end
    end else if (stepLevel && !mPrev[i]) begin
      mAct[i] = 1; mN[i] = 0; stepNow = 1;
    end
    mPrev[i] = stepLevel;
    mPulse[i] = 0; mCarry[i] = 0;
    if (load) mVal[i] = int'(loadValue);
    else if (stepNow) begin
      t = down ? mVal[i] - 1 : mVal[i] + 1;
      if (t < 0 || t > 15) begin
        if (wrapEnable) begin
          mVal[i] = (t + 16) % 16; mPulse[i] = 1; mCarry[i] = 1;
        end
      end else begin
        mVal[i] = t; mPulse[i] = 1;
      end
    end
  endtask

  task automatic stepClock();
    @(posedge clock);
    if (reset) modelReset();
    else begin
      modelStep(0);
      modelStep(1);
    end
    #1;
  endtask

  function automatic logic [13:0] obs();
    return {vA, spA, cA, hA, vB, spB, cB, hB};
  endfunction

  function automatic logic [13:0] expv();
    return {4'(mVal[0]), mPulse[0], mCarry[0], mAct[0], 4'(mVal[1]), mPulse[1], mCarry[1], mAct[1]};
  endfunction

  function automatic logic nextTick();
    return !tick && ($urandom_range(0, 2) == 0);
  endfunction

  task automatic doReset();
    tick = 0; stepLevel = 0; load = 0;
    reset = 1; #1; modelReset();
    stepClock(); stepClock();
    reset = 0;
    stepClock();
  endtask

  task automatic test_reset();
    modelReset();
    #2;
    total++; if (obs() !== 14'h0) begin bad++; $display("FAIL reset_async got=%h want=0", obs()); end
    stepClock(); stepClock();
    reset = 0;
    stepClock();
    total++; if (obs() !== 14'h0) begin bad++; $display("FAIL reset_idle got=%h want=0", obs()); end
    total++; if (obs() !== expv()) begin bad++; $display("FAIL reset_model got=%h want=%h", obs(), expv()); end
  endtask

  task automatic test_single_press();
    int tk = 0, pa = 1;
    bit sawHold;
    wrapEnable = 1; down = 0;
    stepLevel = 1; tick = 0; stepClock();
    total++; if ({vA, spA, hA} !== {4'h1, 1'b1, 1'b1}) begin bad++; $display("FAIL press_latency got=%h/%b/%b want=1/1/1", vA, spA, hA); end
    tick = 0; stepClock();
    total++; if (spA !== 1'b0) begin bad++; $display("FAIL press_pulse_width got=%b want=0", spA); end
    sawHold = hA;
    for (int g = 0; g < 1000 && tk < 10; g++) begin
      tick = nextTick(); stepClock();
      if (tick) tk++;
      if (spA) pa++;
      total++; if (obs() !== expv()) begin bad++; $display("FAIL single_press_cyc got=%h want=%h", obs(), expv()); end
    end
    tick = 0; stepLevel = 0; stepClock();
    total++; if ({vA, hA, sawHold} !== {4'h1, 1'b0, 1'b1} || pa != 1) begin
      bad++; $display("FAIL single_press got v=%h h=%b held=%b pulses=%0d want v=1 h=0 held=1 pulses=1", vA, hA, sawHold, pa);
    end
  endtask

  task automatic test_auto_repeat();
    int tk = 0, pb = 1;
    doReset();
    stepLevel = 1; tick = 0; stepClock();
    for (int g = 0; g < 1000 && tk < 11; g++) begin
      tick = nextTick(); stepClock();
      if (tick) tk++;
      if (spB) pb++;
      total++; if (obs() !== expv()) begin bad++; $display("FAIL auto_repeat_cyc got=%h want=%h", obs(), expv()); end
    end
    tick = 0; stepLevel = 0; stepClock();
    total++; if (vB !== 4'h5 || pb != 5) begin bad++; $display("FAIL auto_repeat got v=%h pulses=%0d want v=5 pulses=5", vB, pb); end
  endtask

  task automatic test_wrap();
    wrapEnable = 1; down = 0; tick = 0;
    load = 1; loadValue = 4'hF; stepClock(); load = 0;
    stepLevel = 1; stepClock();
    total++; if ({vA, cA, vB, cB} !== {4'h0, 1'b1, 4'h0, 1'b1}) begin bad++; $display("FAIL wrap_up got=%h/%b want=0/1", vA, cA); end
    stepClock();
    total++; if ({cA, cB} !== 2'b00) begin bad++; $display("FAIL wrap_carry_width got=%b want=00", {cA, cB}); end
    stepLevel = 0; stepClock();
    down = 1; stepLevel = 1; stepClock();
    total++; if ({vA, cA, spA} !== {4'hF, 1'b1, 1'b1}) begin bad++; $display("FAIL wrap_down got=%h/%b want=F/1", vA, cA); end
    stepLevel = 0; stepClock();
  endtask

  task automatic test_saturate();
    wrapEnable = 0; down = 0; tick = 0;
    load = 1; loadValue = 4'hF; stepClock(); load = 0;
    stepLevel = 1; stepClock();
    total++; if ({vA, spA, cA, vB, spB, cB} !== {4'hF, 2'b00, 4'hF, 2'b00}) begin bad++; $display("FAIL sat_up got=%h/%b/%b want=F/0/0", vA, spA, cA); end
    stepLevel = 0; stepClock();
    load = 1; loadValue = 4'h0; stepClock(); load = 0;
    down = 1; stepLevel = 1; stepClock();
    total++; if ({vA, spA, cA} !== {4'h0, 2'b00}) begin bad++; $display("FAIL sat_down got=%h/%b/%b want=0/0/0", vA, spA, cA); end
    stepLevel = 0; stepClock();
    total++; if (obs() !== expv()) begin bad++; $display("FAIL sat_model got=%h want=%h", obs(), expv()); end
  endtask

  task automatic test_load_collision();
    bit found = 0;
    wrapEnable = 1; down = 0; tick = 0;
    stepLevel = 1; load = 1; loadValue = 4'h9; stepClock(); load = 0;
    total++; if ({vB, spB, hB} !== {4'h9, 1'b0, 1'b1}) begin bad++; $display("FAIL load_collide got=%h/%b/%b want=9/0/1", vB, spB, hB); end
    for (int g = 0; g < 200 && !found; g++) begin
      tick = nextTick(); stepClock();
      if (spB) found = 1;
      total++; if (obs() !== expv()) begin bad++; $display("FAIL load_collide_cyc got=%h want=%h", obs(), expv()); end
    end
    total++; if (!found || vB !== 4'hA) begin bad++; $display("FAIL load_repeat got found=%b v=%h want 1/A", found, vB); end
    tick = 0; stepLevel = 0; stepClock();
  endtask

  task automatic test_reset_mid_repeat();
    int pb = 0, pulses = 0;
    wrapEnable = 1; down = 0; tick = 0;
    stepLevel = 1; stepClock();
    for (int g = 0; g < 400 && pb < 2; g++) begin
      tick = nextTick(); stepClock();
      if (spB) pb++;
    end
    tick = 0;
    #2 reset = 1; #1; modelReset();
    total++; if (obs() !== 14'h0) begin bad++; $display("FAIL reset_mid_async got=%h want=0", obs()); end
    stepClock(); stepClock();
    reset = 0;
    for (int g = 0; g < 60; g++) begin
      tick = nextTick(); stepClock();
      if (spA || spB) pulses++;
    end
    total++; if (pulses != 0 || {vA, vB, hA, hB} !== 10'h0) begin bad++; $display("FAIL reset_held got pulses=%0d v=%h/%h want 0", pulses, vA, vB); end
    tick = 0; stepLevel = 0; stepClock();
    stepLevel = 1; stepClock();
    total++; if ({vA, vB} !== {4'h1, 4'h1}) begin bad++; $display("FAIL reset_repress got=%h/%h want=1/1", vA, vB); end
    stepLevel = 0; stepClock();
  endtask

  task automatic test_random();
    logic prevSp = 0;
    for (int g = 0; g < 3000; g++) begin
      tick = nextTick();
      if ($urandom_range(0, 19) == 0) stepLevel = ~stepLevel;
      down = ($urandom_range(0, 7) == 0) ? ~down : down;
      if ($urandom_range(0, 49) == 0) wrapEnable = ~wrapEnable;
      load = ($urandom_range(0, 29) == 0);
      loadValue = 4'($urandom_range(0, 15));
      stepClock();
      total++; if (obs() !== expv()) begin bad++; $display("FAIL random_cyc%0d got=%h want=%h", g, obs(), expv()); end
      if (prevSp && spB) begin total++; bad++; $display("FAIL random_double_pulse got=11 want=not both"); end
      prevSp = spB;
    end
    load = 0; tick = 0; stepLevel = 0; stepClock();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_auto_repeat();
    test_wrap();
    test_saturate();
    test_load_collision();
    test_reset_mid_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
